ahb_oor_err_slave: RTL
======================

// Module: ahb_oor_err_slave
// PURPOSE
// - AHB-Lite default slave sitting directly downstream of the out-of-range address filter.
// - Consumes the filter's per-transfer error flag and returns the mandatory two-cycle ERROR response.
// - Captures the first faulting address and direction, and counts faults.
// - Raises a sticky level interrupt so software can diagnose stray accesses.
// PARAMETERS
// - ADDR_W  32  width of haddr_i / err_addr_o
// - CNT_W   8   width of saturating fault counter err_cnt_o
// PORTS
// - clk_i        in   1       single clock; all state updates on rising edge
// - rst_ni       in   1       reset, asynchronous assert, active-low
// - error_sel_i  in   1       filter error flag for the current address phase (no slave matched)
// - htrans_i     in   2       AHB HTRANS of the current address phase
// - hwrite_i     in   1       AHB HWRITE of the current address phase
// - haddr_i      in   ADDR_W  AHB HADDR of the current address phase
// - hready_i     in   1       bus-level HREADY (address phase completes when high)
// - hreadyout_o  out  1       this slave's HREADYOUT
// - hresp_o      out  1       this slave's HRESP (1 = ERROR)
// - err_clr_i    in   1       1-cycle pulse from software: clear capture, counter and irq
// - err_addr_o   out  ADDR_W  address of first unacknowledged fault
// - err_write_o  out  1       direction of that fault (1 = write)
// - err_cnt_o    out  CNT_W   faults since last clear, saturating
// - err_irq_o    out  1       sticky fault indication, level
// BEHAVIOUR
// - Reset (rst_ni low, async):
//   - state = IDLE, hreadyout_o = 1, hresp_o = 0.
//   - err_addr_o = 0, err_write_o = 0, err_cnt_o = 0, err_irq_o = 0.
// - Accepted fault: `acc = error_sel_i & hready_i & htrans_i[1]` (NONSEQ/SEQ only).
//   - IDLE/BUSY transfers never fault, even with error_sel_i high.
// - FSM, registered outputs:
//   - IDLE: hreadyout_o = 1, hresp_o = 0. acc -> ERR1; else stay.
//   - ERR1: hreadyout_o = 0, hresp_o = 1. Unconditionally -> ERR2.
//   - ERR2: hreadyout_o = 1, hresp_o = 1. acc -> ERR1 (back-to-back fault); else -> IDLE.
//   - ERR1 ignores all inputs: hready_i is low bus-wide, so no new address phase exists.
// - Latency: ERROR response starts the cycle after the faulting address phase.
//   - Each fault costs exactly 2 data-phase cycles; no OKAY cycle between back-to-back faults.
// - Capture on each acc:
//   - If err_irq_o == 0: latch haddr_i -> err_addr_o and hwrite_i -> err_write_o.
//   - If err_irq_o == 1: hold the first capture; later faults only count.
// - Counter: +1 per acc; saturates at 2^CNT_W-1 (no wrap).
// - err_irq_o: set on acc; cleared only by err_clr_i.
// - err_clr_i alone: err_cnt_o = 0, err_irq_o = 0; err_addr_o / err_write_o hold their last value.
// - err_clr_i with acc in the same cycle: new fault wins.
//   - err_cnt_o = 1, err_irq_o = 1, new address/direction captured.
//   - err_clr_i never affects the FSM or an in-flight ERROR response.
// - Reset asserted mid-ERR1/ERR2: immediate return to IDLE reset values.
//   - The bus master is reset alongside, so the partial response is discarded.
// - hresp_o is never 1 while state == IDLE; hreadyout_o is never 0 outside ERR1.
// TESTING
// - Single NONSEQ read at 0xF000_0000 with error_sel_i = 1 -> hreadyout/hresp 0/1 then 1/1, then 1/0.
//   - Also: err_addr_o = 0xF000_0000, err_write_o = 0, err_cnt_o = 1, err_irq_o = 1.
// - Two NONSEQ writes, second issued in ERR2 cycle -> ERR1, ERR2, ERR1, ERR2.
//   - Also: err_cnt_o = 2, err_addr_o = first address, err_write_o = 1.
// - error_sel_i = 1 with htrans_i = IDLE, then BUSY -> hreadyout_o = 1, hresp_o = 0, counters unchanged.
// - 300 faults with CNT_W = 8 -> err_cnt_o stops at 255.
//   - Then err_clr_i pulse -> err_cnt_o = 0, err_irq_o = 0.
// - err_clr_i coincident with fault at 0x1234_5678 -> err_cnt_o = 1, err_irq_o = 1, err_addr_o = 0x1234_5678.
// - rst_ni driven low during ERR1 -> same cycle (async): hreadyout_o = 1, hresp_o = 0, all capture outputs 0.

Source files
------------

// File: rtl/ahb_oor_err_slave.sv
// AHB-Lite default slave for out-of-range accesses. Returns the two-cycle
// ERROR response for every accepted faulting transfer, records the first
// unacknowledged fault and counts faults for software diagnosis.
module ahb_oor_err_slave #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned CNT_W  = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              error_sel_i,
    input  logic [1:0]        htrans_i,
    input  logic              hwrite_i,
    input  logic [ADDR_W-1:0] haddr_i,
    input  logic              hready_i,
    output logic              hreadyout_o,
    output logic              hresp_o,
    input  logic              err_clr_i,
    output logic [ADDR_W-1:0] err_addr_o,
    output logic              err_write_o,
    output logic [CNT_W-1:0]  err_cnt_o,
    output logic              err_irq_o
);

    typedef enum logic [1:0] {StIdle, StErr1, StErr2} state_e;

    localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

    state_e            state_q, state_d;
    logic              hreadyout_q, hresp_q;
    logic [ADDR_W-1:0] err_addr_q, err_addr_d;
    logic              err_write_q, err_write_d;
    logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;
    logic              err_irq_q, err_irq_d;
    logic              acc;

    // A fault is accepted only for NONSEQ/SEQ address phases that complete.
    // ERR1 holds HREADY low bus-wide, so nothing can be accepted there.
    assign acc = error_sel_i & hready_i & htrans_i[1] & (state_q != StErr1);

    // Next-state logic for the ERROR response sequencer.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  state_d = acc ? StErr1 : StIdle;
            StErr1:  state_d = StErr2;
            StErr2:  state_d = acc ? StErr1 : StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Next-state logic for capture, saturating counter and sticky irq.
    // A fault in the same cycle as a clear wins over the clear.
    always_comb begin
        err_addr_d  = err_addr_q;
        err_write_d = err_write_q;
        err_cnt_d   = err_cnt_q;
        err_irq_d   = err_irq_q;
        if (acc) begin
            if (!err_irq_q || err_clr_i) begin
                err_addr_d  = haddr_i;
                err_write_d = hwrite_i;
            end
            if (err_clr_i) begin
                err_cnt_d = CntOne;
            end else if (err_cnt_q != CntMax) begin
                err_cnt_d = err_cnt_q + CntOne;
            end
            err_irq_d = 1'b1;
        end else if (err_clr_i) begin
            err_cnt_d = '0;
            err_irq_d = 1'b0;
        end
    end

    // State and registered response outputs, decoded from the next state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            hreadyout_q <= 1'b1;
            hresp_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            hreadyout_q <= (state_d != StErr1);
            hresp_q     <= (state_d != StIdle);
        end
    end

    // Fault capture registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_addr_q  <= '0;
            err_write_q <= 1'b0;
            err_cnt_q   <= '0;
            err_irq_q   <= 1'b0;
        end else begin
            err_addr_q  <= err_addr_d;
            err_write_q <= err_write_d;
            err_cnt_q   <= err_cnt_d;
            err_irq_q   <= err_irq_d;
        end
    end

    assign hreadyout_o = hreadyout_q;
    assign hresp_o     = hresp_q;
    assign err_addr_o  = err_addr_q;
    assign err_write_o = err_write_q;
    assign err_cnt_o   = err_cnt_q;
    assign err_irq_o   = err_irq_q;

endmodule
